// File: rtl/seg7_scan_if.sv
// Bundle of the BCD digit inputs, adjust controls and display drive lines
// shared between the stopwatch side and the 4-digit scanning display.
interface seg7_scan_if;
  logic [3:0] min1;
  logic [3:0] min0;
  logic [3:0] sec1;
  logic [3:0] sec0;
  logic [1:0] adjust;
  logic       select;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output min1, min0, sec1, sec0, adjust, select,
    input  an, seg, dp
  );

  modport slave (
    input  min1, min0, sec1, sec0, adjust, select,
    output an, seg, dp
  );
endinterface

// File: rtl/seg7_scan_display.sv
// Time-multiplexed common-anode 4-digit 7-segment driver. Digits are
// snapshotted once per scan frame so a frame never mixes two counts, and
// the digit pair being adjusted blinks while adjust mode is active.
module seg7_scan_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  seg7_scan_if.slave bus
);
  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [RW-1:0]   ref_cnt;
  logic [1:0]      idx;
  logic [BW-1:0]   blink_cnt;
  logic            blink_ph;
  logic [3:0][3:0] snap;       // [0]=sec0 [1]=sec1 [2]=min0 [3]=min1
  logic            snap_valid;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  logic ref_wrap, blink_wrap, adj_mode, in_sel_pair;

  assign ref_wrap    = (ref_cnt == RW'(REFRESH_DIV - 1));
  assign blink_wrap  = (blink_cnt == BW'(BLINK_DIV - 1));
  assign adj_mode    = |bus.adjust;
  // select=0 blinks minutes (idx 2,3); select=1 blinks seconds (idx 0,1)
  assign in_sel_pair = bus.select ? ~idx[1] : idx[1];

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;  // non-BCD shows a dash
    endcase
  endfunction

  // Refresh divider and digit index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_cnt <= '0;
      idx     <= '0;
    end else begin
      ref_cnt <= ref_wrap ? '0 : ref_cnt + RW'(1);
      if (ref_wrap) idx <= idx + 2'd1;
    end
  end

  // Snapshot on the first edge after reset and at every frame boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap       <= '0;
      snap_valid <= 1'b0;
    end else begin
      snap_valid <= 1'b1;
      if (!snap_valid || (ref_wrap && idx == 2'd3))
        snap <= {bus.min1, bus.min0, bus.sec1, bus.sec0};
    end
  end

  // Blink timer runs only in adjust mode so each entry starts visible
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b1;
    end else if (adj_mode) begin
      blink_cnt <= blink_wrap ? '0 : blink_cnt + BW'(1);
      if (blink_wrap) blink_ph <= ~blink_ph;
    end else begin
      blink_cnt <= '0;
      blink_ph  <= 1'b1;
    end
  end

  // Next display drive: dark until a snapshot exists or while blanked
  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (snap_valid && !(adj_mode && !blink_ph && in_sel_pair)) begin
      an_d  = ~(4'b0001 << idx);
      seg_d = decode(snap[idx]);
      dp_d  = (idx != 2'd2);
    end
  end

  // Registered outputs keep inputs off any combinational output path
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q  <= 4'b1111;
      seg_q <= 7'b1111111;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;
endmodule
